// File: rtl/t06_score_pkg.sv
// -----------------------------------------------------------------------------
// t06_score_pkg
// Shared definitions for the score tracker and its sequential binary-to-BCD
// converter.
//   MAX_SCORE_DEF : default saturation point of the game score
//   BCD_W         : width of a packed 3-digit BCD value {hundreds,tens,ones}
//   SHIFT_CNT     : number of double-dabble shift steps for an 8-bit input
//   conv_state_t  : converter FSM states
// -----------------------------------------------------------------------------
package t06_score_pkg;

  localparam int MAX_SCORE_DEF = 50;
  localparam int BCD_W         = 12;
  localparam int SHIFT_CNT     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage : t06_score_pkg

// File: rtl/t06_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// t06_bin2bcd_seq
// Sequential double-dabble converter: one shift per clock, 8 shifts per
// conversion. A start pulse latches the binary input and clears the BCD
// accumulator; a start while SHIFT or DONE abandons the running conversion and
// reloads, so only the newest input ever reaches DONE.
// Ports:
//   clk     in   1      system clock
//   nreset  in   1      synchronous reset, active-high
//   start   in   1      load bin and (re)start the conversion
//   bin     in   WIDTH  binary value to convert
//   bcd     out  12     BCD result {hundreds,tens,ones}; meaningful while done=1
//   done    out  1      high for the single cycle the converter sits in DONE
// -----------------------------------------------------------------------------
module t06_bin2bcd_seq
  import t06_score_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  localparam logic [3:0] LAST_CNT = 4'(SHIFT_CNT - 1);

  conv_state_t      state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] shreg;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;

  // Double-dabble correction: a digit of 5..9 would become 10..18 after the
  // shift, so add 3 first to make the shift carry into the next digit. 4-bit
  // arithmetic only; the carry out is deliberately dropped.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  always_comb begin
    acc_adj = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
  end

  // Control: FSM and shift counter
  always_ff @(posedge clk) begin
    if (nreset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else if (start) begin
      state <= SHIFT;
      cnt   <= 4'd0;
    end else begin
      case (state)
        SHIFT: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: shift register and BCD accumulator
  always_ff @(posedge clk) begin
    if (start) begin
      shreg <= bin;
      acc   <= '0;
    end else if (state == SHIFT) begin
      acc   <= {acc_adj[BCD_W-2:0], shreg[WIDTH-1]};
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign bcd  = acc;
  assign done = (state == DONE);

endmodule : t06_bin2bcd_seq

// File: rtl/t06_score_tracker.sv
// -----------------------------------------------------------------------------
// t06_score_tracker
// Holds the game score and the session high score, flags a win when the score
// reaches MAX_SCORE, and keeps a 3-digit BCD copy of both values for the text
// formatter. Two lock-stepped converters run after every change; the BCD
// outputs only move when both finish on an unchanged score.
// Ports:
//   clk         in   1      system clock
//   nreset      in   1      synchronous reset, active-high
//   score_inc   in   1      one-cycle pulse: apple eaten
//   score_clr   in   1      one-cycle pulse: new game (score only)
//   score       out  WIDTH  current score
//   high_score  out  WIDTH  highest score since reset
//   score_bcd   out  12     BCD of score
//   high_bcd    out  12     BCD of high_score
//   bcd_valid   out  1      both BCD outputs match the binary values
//   win         out  1      one-cycle pulse when score becomes MAX_SCORE
// -----------------------------------------------------------------------------
module t06_score_tracker
  import t06_score_pkg::*;
#(
  parameter int MAX_SCORE = MAX_SCORE_DEF,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             score_inc,
  input  logic             score_clr,
  output logic [WIDTH-1:0] score,
  output logic [WIDTH-1:0] high_score,
  output logic [BCD_W-1:0] score_bcd,
  output logic [BCD_W-1:0] high_bcd,
  output logic             bcd_valid,
  output logic             win
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_SCORE);

  logic [WIDTH-1:0] score_nxt;
  logic [WIDTH-1:0] high_nxt;
  logic             chg;
  logic             pending;
  logic [BCD_W-1:0] s_bcd;
  logic [BCD_W-1:0] h_bcd;
  logic             s_done;
  logic             h_done;
  logic             conv_done;

  // Clear has priority over increment; the score saturates at MAX_SCORE.
  always_comb begin
    score_nxt = score;
    if (score_clr) begin
      score_nxt = '0;
    end else if (score_inc && (score < MAX_V)) begin
      score_nxt = score + WIDTH'(1);
    end
  end

  // High score follows the new score on the same edge it is exceeded.
  always_comb begin
    high_nxt = (score_nxt > high_score) ? score_nxt : high_score;
  end

  // high_score only moves when score does, so a score change covers both.
  assign chg = (score_nxt != score);

  // Both converters restart together one edge after any change, so their done
  // outputs coincide. pending still being high in DONE means a newer change has
  // just restarted them: that result is stale and is dropped.
  t06_bin2bcd_seq #(.WIDTH(WIDTH)) u_conv_score (
    .clk    (clk),
    .nreset (nreset),
    .start  (pending),
    .bin    (score),
    .bcd    (s_bcd),
    .done   (s_done)
  );

  t06_bin2bcd_seq #(.WIDTH(WIDTH)) u_conv_high (
    .clk    (clk),
    .nreset (nreset),
    .start  (pending),
    .bin    (high_score),
    .bcd    (h_bcd),
    .done   (h_done)
  );

  assign conv_done = s_done & h_done;

  // Score, win and BCD publication
  always_ff @(posedge clk) begin
    if (nreset) begin
      score      <= '0;
      high_score <= '0;
      win        <= 1'b0;
      pending    <= 1'b0;
      bcd_valid  <= 1'b1;
      score_bcd  <= '0;
      high_bcd   <= '0;
    end else begin
      score      <= score_nxt;
      high_score <= high_nxt;
      // Only an increment can land on MAX_SCORE (MAX_SCORE >= 1), and a
      // saturated increment is not a change, so this fires once per game.
      win        <= chg && (score_nxt == MAX_V);
      pending    <= chg;
      if (chg) begin
        bcd_valid <= 1'b0;
      end else if (conv_done && !pending) begin
        score_bcd <= s_bcd;
        high_bcd  <= h_bcd;
        bcd_valid <= 1'b1;
      end
    end
  end

endmodule : t06_score_tracker
